// File: rtl/ltc2320_pkg.sv
// Shared LTC2320 constants and types, reused by the capture scheduler and by
// the downstream FIFO / register blocks.
`timescale 1ns/1ps
package ltc2320_pkg;
  localparam int LTC2320_LANES      = 8;
  localparam int LTC2320_FRAME_BITS = 16;
  localparam int LTC2320_DATA_BITS  = 13;

  typedef logic [LTC2320_DATA_BITS-1:0] ain_word_t;
  typedef logic [2:0]                   ch_idx_t;
  typedef logic [LTC2320_LANES-1:0]     lane_mask_t;
endpackage

// File: rtl/ltc2320_readout_scheduler_if.sv
// Word port between the LTC2320 scheduler and the adc_clkout-side FIFO write port.
//   out_valid   : word presented (master -> slave)
//   out_ready   : word accepted (slave -> master)
//   out_channel : channel index of the word
//   out_data    : DATA_BITS result
//   out_last    : last pending word of its frame
`timescale 1ns/1ps
interface ltc2320_readout_scheduler_if import ltc2320_pkg::*; #(
  parameter int DATA_BITS = LTC2320_DATA_BITS
) ();
  logic                 out_valid;
  logic                 out_ready;
  ch_idx_t              out_channel;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_last;

  modport master (output out_valid, out_channel, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_channel, out_data, out_last, output out_ready);
endinterface

// File: rtl/ltc2320_ch_pick.sv
// Fixed-priority pick: lowest set bit of the pending mask wins.
//   mask   : pending channel mask
//   idx    : index of the lowest set bit (0 when mask is empty)
//   any    : mask non-zero
//   onehot : exactly one bit set
`timescale 1ns/1ps
module ltc2320_ch_pick import ltc2320_pkg::*; (
  input  lane_mask_t mask,
  output ch_idx_t    idx,
  output logic       any,
  output logic       onehot
);
  always_comb begin
    idx = '0;
    for (int i = LTC2320_LANES - 1; i >= 0; i--)
      if (mask[i]) idx = ch_idx_t'(i);
  end

  assign any    = |mask;
  // clearing the lowest set bit leaves nothing only when a single bit was set
  assign onehot = any && ((mask & (mask - lane_mask_t'(1))) == '0);
endmodule

// File: rtl/ltc2320_readout_scheduler.sv
// LTC2320 capture scheduler, clocked by the ADC's echoed adc_clkout.
// Deserialises 8 SDO lanes, latches each frame into a holding buffer and
// drains the enabled channels one word per cycle over a valid/ready port.
//   adc_clkout    : capture clock (bursty)
//   reset_150mhz  : async active-high reset
//   adc_sdo       : serial lanes, lane i = channel i, MSB first
//   ch_enable     : channel mask, sampled at frame end
//   out_if        : word port (master side)
//   overrun       : 1-cycle pulse, new frame arrived with words still pending
//   overrun_count : saturating overrun count, only with LTC2320_OVERRUN_COUNT_EN
// Optional macro: LTC2320_OVERRUN_COUNT_EN builds the 8-bit overrun counter;
// without it overrun_count is tied to 0.
`timescale 1ns/1ps
module ltc2320_readout_scheduler import ltc2320_pkg::*; #(
  parameter int FRAME_BITS = LTC2320_FRAME_BITS,
  parameter int DATA_BITS  = LTC2320_DATA_BITS   // must be < FRAME_BITS
) (
  input  logic                     adc_clkout,
  input  logic                     reset_150mhz,
  input  logic [LTC2320_LANES-1:0] adc_sdo,
  input  logic [LTC2320_LANES-1:0] ch_enable,
  ltc2320_readout_scheduler_if.master out_if,
  output logic                     overrun,
  output logic [7:0]               overrun_count
);
  localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  logic [CNT_W-1:0]                         bit_cnt;
  logic                                     frame_end;
  logic [LTC2320_LANES-1:0][DATA_BITS-1:0]  hold;
  lane_mask_t                               pending, take;
  ch_idx_t                                  sel;
  logic                                     any, onehot, accept;

  assign frame_end = (bit_cnt == CNT_W'(FRAME_BITS - 1));

  for (genvar i = 0; i < LTC2320_LANES; i++) begin : g_lane
    // The frame word is {sr, adc_sdo}; its MSB would age out on the very
    // edge it is used, so the shifter keeps only FRAME_BITS-1 bits and the
    // kept result bits sr[FRAME_BITS-2 -: DATA_BITS] equal word[15:3].
    logic [FRAME_BITS-2:0] sr;
    logic [DATA_BITS-1:0]  hold_q;

    always_ff @(posedge adc_clkout or posedge reset_150mhz) begin
      if (reset_150mhz) begin
        sr     <= '0;
        hold_q <= '0;
      end else begin
        sr <= {sr[FRAME_BITS-3:0], adc_sdo[i]};
        if (frame_end) hold_q <= sr[FRAME_BITS-2 -: DATA_BITS];
      end
    end

    assign hold[i] = hold_q;
  end

  ltc2320_ch_pick u_pick (
    .mask   (pending),
    .idx    (sel),
    .any    (any),
    .onehot (onehot)
  );

  assign accept = any && out_if.out_ready;
  assign take   = accept ? (lane_mask_t'(1) << sel) : '0;

  always_ff @(posedge adc_clkout or posedge reset_150mhz) begin
    if (reset_150mhz) begin
      bit_cnt <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      bit_cnt <= frame_end ? '0 : bit_cnt + CNT_W'(1);
      // a word accepted on the frame-end edge is delivered, not overrun
      overrun <= frame_end && ((pending & ~take) != '0);
      pending <= frame_end ? ch_enable : (pending & ~take);
    end
  end

  assign out_if.out_valid   = any;
  assign out_if.out_channel = sel;
  assign out_if.out_data    = hold[sel];
  assign out_if.out_last    = onehot;

`ifdef LTC2320_OVERRUN_COUNT_EN
  logic [7:0] ovr_cnt;
  always_ff @(posedge adc_clkout or posedge reset_150mhz) begin
    if (reset_150mhz)                  ovr_cnt <= '0;
    else if (overrun && ovr_cnt != '1) ovr_cnt <= ovr_cnt + 8'd1;
  end
  assign overrun_count = ovr_cnt;
`else
  assign overrun_count = '0;
`endif
endmodule

// File: tb/tb_ltc2320_readout_scheduler.sv
// Self-checking bench for ltc2320_readout_scheduler. Frames are described in
// tables (per-lane values, enable mask, per-edge ready); the expected word
// stream is derived frame by frame: the k-th pending word of a frame goes out
// on the k-th ready-high edge of the following frame, leftovers mean overrun.
`timescale 1ns/1ps
module tb_ltc2320_readout_scheduler;
  import ltc2320_pkg::*;

  logic       adc_clkout = 1'b0;
  logic       reset_150mhz = 1'b1;
  logic [7:0] adc_sdo = '0;
  logic [7:0] ch_enable = '0;
  logic       overrun;
  logic [7:0] overrun_count;
  bit         clk_run = 1'b1;
  bit         pause_en = 1'b0;

  ltc2320_readout_scheduler_if bus ();

  ltc2320_readout_scheduler dut (
    .adc_clkout    (adc_clkout),
    .reset_150mhz  (reset_150mhz),
    .adc_sdo       (adc_sdo),
    .ch_enable     (ch_enable),
    .out_if        (bus),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  always begin
    #5;
    if (clk_run) adc_clkout = ~adc_clkout;
  end

  int n_checks = 0, n_err = 0;

  // monitor: posedge count, accepted words and overrun pulses
  int          cyc = 0;
  int          ovr_n = 0, ovr_cyc = 0;
  logic [16:0] got_q[$];
  int          got_cyc[$];

  always @(posedge adc_clkout) cyc <= cyc + 1;

  always @(negedge adc_clkout) begin
    if (!reset_150mhz) begin
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back({bus.out_channel, bus.out_data, bus.out_last});
        got_cyc.push_back(cyc);
      end
      if (overrun) begin
        ovr_n   <= ovr_n + 1;
        ovr_cyc <= cyc;
      end
    end
  end

  // scenario tables
  logic [15:0] fv   [320][8];
  logic [7:0]  fen  [320];
  logic [15:0] frdy [320];
  int          fe_tab [320];

  logic [16:0] exp_q[$];
  int          exp_cyc[$];
  int          exp_ovr;

  task automatic fill(input int f, input logic [7:0] en, input logic [15:0] rdy);
    for (int i = 0; i < 8; i++) fv[f][i] = 16'($urandom);
    fen[f]  = en;
    frdy[f] = rdy;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      ch_enable = fen[f];
      for (int k = 0; k < 16; k++) begin
        for (int i = 0; i < 8; i++) adc_sdo[i] = fv[f][i][15-k];
        bus.out_ready = frdy[f][k];
        @(posedge adc_clkout); #1;
      end
      fe_tab[f] = cyc;
      if (pause_en && $urandom_range(0, 3) == 0) begin
        clk_run = 1'b0; #37; clk_run = 1'b1;
      end
    end
  endtask

  // reference: frame f drains during frame f+1, one word per ready-high edge
  task automatic build_expect(input int n);
    int chs[$];
    int j;
    exp_q.delete(); exp_cyc.delete(); exp_ovr = 0;
    for (int f = 0; f + 1 < n; f++) begin
      chs.delete();
      for (int c = 0; c < 8; c++) if (fen[f][c]) chs.push_back(c);
      j = 0;
      for (int e = 0; e < 16 && j < chs.size(); e++) begin
        if (frdy[f+1][e]) begin
          exp_q.push_back({3'(chs[j]), fv[f][chs[j]][15:3], 1'(j == chs.size() - 1)});
          exp_cyc.push_back(fe_tab[f] + e);
          j++;
        end
      end
      if (j < chs.size()) exp_ovr++;
    end
  endtask

  function automatic int exp_count(input int ovr);
`ifdef LTC2320_OVERRUN_COUNT_EN
    return (ovr > 255) ? 255 : ovr;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    reset_150mhz = 1'b1; bus.out_ready = 1'b0; adc_sdo = '0; ch_enable = '0;
    repeat (2) begin @(posedge adc_clkout); #1; end
    reset_150mhz = 1'b0;
  endtask

  task automatic test_reset();
    reset_150mhz = 1'b1; bus.out_ready = 1'b1; adc_sdo = 8'hFF; ch_enable = 8'hFF;
    repeat (3) begin @(posedge adc_clkout); #1; end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_channel !== 3'd0) begin n_err++; $display("FAIL rst_channel: got %0d want 0", bus.out_channel); end
    n_checks++; if (bus.out_data !== 13'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b want 0", bus.out_last); end
    n_checks++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_checks++; if (overrun_count !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", overrun_count); end
    fill(0, 8'hFF, 16'h0000);
    reset_150mhz = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 8; i++) adc_sdo[i] = fv[0][i][15-k];
      bus.out_ready = 1'b0;
      @(posedge adc_clkout); #1;
      if (k == 14) begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_edge15_valid: got %b want 0", bus.out_valid); end
      end
    end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_edge16_valid: got %b want 1", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== fv[0][0][15:3]) begin n_err++; $display("FAIL rst_first_data: got %h want %h", bus.out_data, fv[0][0][15:3]); end
  endtask

  task automatic test_basic();
    int base, ovr_base;
    logic [16:0] w;
    do_reset();
    base = got_q.size(); ovr_base = ovr_n;
    for (int i = 0; i < 8; i++) fv[0][i] = 16'(16'h1000 * i + 16'h0008);
    fen[0] = 8'hFF; frdy[0] = 16'hFFFF;
    fill(1, 8'h00, 16'hFFFF);
    run_frames(2);
    build_expect(2);
    for (int k = 0; k < 8; k++) begin
      w = {3'(k), 13'(13'h200 * k + 1), 1'(k == 7)};
      n_checks++;
      if (base + k >= got_q.size() || got_q[base+k] !== w || got_cyc[base+k] != fe_tab[0] + k) begin
        n_err++; $display("FAIL basic_word%0d: got %h want %h at cycle %0d", k,
                          (base + k < got_q.size()) ? got_q[base+k] : 17'h0, w, fe_tab[0] + k);
      end
    end
    n_checks++;
    if (got_q.size() - base != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
    n_checks++;
    if (ovr_n - ovr_base != 0) begin n_err++; $display("FAIL basic_overrun: got %0d want 0", ovr_n - ovr_base); end
  endtask

  task automatic test_sparse();
    int base, ovr_base;
    logic [2:0] chs [3];
    chs[0] = 3'd2; chs[1] = 3'd5; chs[2] = 3'd7;
    do_reset();
    base = got_q.size(); ovr_base = ovr_n;
    fill(0, 8'b1010_0100, 16'hFFFF);
    fill(1, 8'h00, 16'hFFFF);
    run_frames(2);
    build_expect(2);
    n_checks++;
    if (got_q.size() - base != 3) begin n_err++; $display("FAIL sparse_count: got %0d want 3", got_q.size() - base); end
    for (int k = 0; k < 3 && base + k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[base+k] !== {chs[k], fv[0][chs[k]][15:3], 1'(k == 2)} || got_q[base+k] !== exp_q[k]) begin
        n_err++; $display("FAIL sparse_word%0d: got %h want %h", k, got_q[base+k], exp_q[k]);
      end
    end
    n_checks++;
    if (ovr_n - ovr_base != exp_ovr) begin n_err++; $display("FAIL sparse_overrun: got %0d want %0d", ovr_n - ovr_base, exp_ovr); end
  endtask

  task automatic test_overrun();
    int base, ovr_base;
    do_reset();
    base = got_q.size(); ovr_base = ovr_n;
    fill(0, 8'hFF, 16'hFFFF);
    fill(1, 8'hFF, 16'h0000);
    fill(2, 8'h00, 16'hFFFF);
    run_frames(3);
    build_expect(3);
    n_checks++;
    if (ovr_n - ovr_base != 1 || exp_ovr != 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", ovr_n - ovr_base); end
    n_checks++;
    if (ovr_cyc != fe_tab[1]) begin n_err++; $display("FAIL ovr_timing: got cycle %0d want %0d", ovr_cyc, fe_tab[1]); end
    n_checks++;
    if (got_q.size() - base != exp_q.size()) begin n_err++; $display("FAIL ovr_count_words: got %0d want %0d", got_q.size() - base, exp_q.size()); end
    for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k] || got_cyc[base+k] != exp_cyc[k]) begin
        n_err++; $display("FAIL ovr_word%0d: got %h @%0d want %h @%0d", k, got_q[base+k], got_cyc[base+k], exp_q[k], exp_cyc[k]);
      end
    end
    n_checks++;
    if (base < got_q.size() && got_q[base] !== {3'd0, fv[1][0][15:3], 1'b0}) begin
      n_err++; $display("FAIL ovr_new_first: got %h want %h", got_q[base], {3'd0, fv[1][0][15:3], 1'b0});
    end
    n_checks++;
    if (overrun_count !== 8'(exp_count(1))) begin n_err++; $display("FAIL ovr_counter: got %0d want %0d", overrun_count, exp_count(1)); end
  endtask

  task automatic test_accept_on_frame_end();
    int base, ovr_base;
    do_reset();
    base = got_q.size(); ovr_base = ovr_n;
    fill(0, 8'hFF, 16'hFFFF);
    fill(1, 8'hFF, 16'hFF00);   // ch7 of frame 0 goes on the frame-end edge
    fill(2, 8'h00, 16'hFFFF);
    run_frames(3);
    build_expect(3);
    n_checks++;
    if (ovr_n - ovr_base != 0) begin n_err++; $display("FAIL fe_accept_overrun: got %0d want 0", ovr_n - ovr_base); end
    n_checks++;
    if (got_q.size() - base != 16) begin n_err++; $display("FAIL fe_accept_count: got %0d want 16", got_q.size() - base); end
    n_checks++;
    if (base + 7 < got_q.size() && (got_q[base+7] !== {3'd7, fv[0][7][15:3], 1'b1} || got_cyc[base+7] != fe_tab[1] - 1)) begin
      n_err++; $display("FAIL fe_accept_ch7: got %h @%0d want %h @%0d", got_q[base+7], got_cyc[base+7], {3'd7, fv[0][7][15:3], 1'b1}, fe_tab[1] - 1);
    end
    for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k] || got_cyc[base+k] != exp_cyc[k]) begin
        n_err++; $display("FAIL fe_accept_word%0d: got %h @%0d want %h @%0d", k, got_q[base+k], got_cyc[base+k], exp_q[k], exp_cyc[k]);
      end
    end
  endtask

  task automatic test_random();
    int base, ovr_base;
    logic [15:0] r;
    do_reset();
    base = got_q.size(); ovr_base = ovr_n;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 3))
        0: r = 16'hFFFF;
        1: r = 16'h0000;
        default: r = 16'($urandom);
      endcase
      fill(f, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), r);
    end
    fill(40, 8'h00, 16'hFFFF);
    pause_en = 1'b1;
    run_frames(41);
    pause_en = 1'b0;
    build_expect(41);
    n_checks++;
    if (got_q.size() - base != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
    for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k] || got_cyc[base+k] != exp_cyc[k]) begin
        n_err++; $display("FAIL rand_word%0d: got %h @%0d want %h @%0d", k, got_q[base+k], got_cyc[base+k], exp_q[k], exp_cyc[k]);
      end
    end
    n_checks++;
    if (ovr_n - ovr_base != exp_ovr) begin n_err++; $display("FAIL rand_overrun: got %0d want %0d", ovr_n - ovr_base, exp_ovr); end
    n_checks++;
    if (overrun_count !== 8'(exp_count(exp_ovr))) begin n_err++; $display("FAIL rand_counter: got %0d want %0d", overrun_count, exp_count(exp_ovr)); end
  endtask

  task automatic test_reset_mid();
    int base, ovr_base;
    do_reset();
    fill(0, 8'hFF, 16'hFFFF);
    fill(1, 8'hFF, 16'h001F);  // five accepts, three words left pending
    run_frames(1);
    ch_enable = fen[1];
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) adc_sdo[i] = fv[1][i][15-k];
      bus.out_ready = frdy[1][k];
      @(posedge adc_clkout); #1;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_channel !== 3'd5) begin
      n_err++; $display("FAIL mid_pre_valid: got %b ch %0d want 1 ch 5", bus.out_valid, bus.out_channel);
    end
    reset_150mhz = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_channel, bus.out_data, bus.out_last, overrun, overrun_count} !== '0) begin
      n_err++; $display("FAIL mid_reset_outputs: got v%b ch%0d d%h l%b o%b c%0d want all 0", bus.out_valid, bus.out_channel,
                        bus.out_data, bus.out_last, overrun, overrun_count);
    end
    do_reset();
    base = got_q.size(); ovr_base = ovr_n;
    fill(0, 8'hFF, 16'h0000);
    fill(1, 8'h00, 16'hFFFF);
    run_frames(2);
    build_expect(2);
    n_checks++;
    if (got_q.size() - base != exp_q.size()) begin n_err++; $display("FAIL mid_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
    for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[base+k] !== exp_q[k] || got_cyc[base+k] != exp_cyc[k]) begin
        n_err++; $display("FAIL mid_word%0d: got %h @%0d want %h @%0d", k, got_q[base+k], got_cyc[base+k], exp_q[k], exp_cyc[k]);
      end
    end
    n_checks++;
    if (ovr_n - ovr_base != 0) begin n_err++; $display("FAIL mid_overrun: got %0d want 0", ovr_n - ovr_base); end
  endtask

`ifdef LTC2320_OVERRUN_COUNT_EN
  task automatic test_saturate();
    int base, ovr_base;
    do_reset();
    base = got_q.size(); ovr_base = ovr_n;
    for (int f = 0; f < 302; f++) fill(f, 8'hFF, 16'h0000);
    fill(302, 8'h00, 16'hFFFF);
    run_frames(303);
    build_expect(303);
    n_checks++;
    if (ovr_n - ovr_base != exp_ovr) begin n_err++; $display("FAIL sat_pulses: got %0d want %0d", ovr_n - ovr_base, exp_ovr); end
    n_checks++;
    if (overrun_count !== 8'd255) begin n_err++; $display("FAIL sat_counter: got %0d want 255", overrun_count); end
    n_checks++;
    if (got_q.size() - base != exp_q.size()) begin n_err++; $display("FAIL sat_words: got %0d want %0d", got_q.size() - base, exp_q.size()); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_sparse();
    test_overrun();
    test_accept_on_frame_end();
    test_reset_mid();
    test_random();
`ifdef LTC2320_OVERRUN_COUNT_EN
    test_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
